sr_latch_ctrl: RTL and testbench

- Synchronous sequencer that owns the active-low NAND SR latch (inputs S, R active-low; outputs Q, Qn).
- Accepts set and reset requests from two requester ports and converts them into timed low pulses on the latch inputs.
- Arbitrates simultaneous requests and guarantees the forbidden S=R=0 condition is never driven.
- Checks the latch's Q after a settle window and reports the result per operation.

---
 rtl/sr_latch_ctrl.sv | 137 +++++++++++++
 tb/tb_sr_latch_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sr_latch_ctrl.sv
// Sequencer for an active-low NAND SR latch: arbitrates set/reset requests,
// drives timed low pulses on S_n/R_n and verifies Q after a settle window.
module sr_latch_ctrl #(
    parameter int unsigned PULSE_CYCLES  = 2,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned CNT_W         = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_req,
    input  logic rst_req,
    input  logic err_clr,
    input  logic Q_fb,
    output logic S_n,
    output logic R_n,
    output logic busy,
    output logic ack,
    output logic ack_op,
    output logic q_state,
    output logic q_valid,
    output logic err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PULSE  = 2'd1,
        SETTLE = 2'd2,
        CHECK  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] PULSE_LOAD  = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             op, op_nxt;
    logic             pref, pref_nxt;
    logic             s_n_nxt, r_n_nxt, busy_nxt;
    logic             ack_nxt, ack_op_nxt;
    logic             q_state_nxt, q_valid_nxt, err_nxt;

    // State and all outputs are registered together so S_n/R_n never glitch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            op      <= 1'b0;
            pref    <= 1'b0;
            S_n     <= 1'b1;
            R_n     <= 1'b1;
            busy    <= 1'b0;
            ack     <= 1'b0;
            ack_op  <= 1'b0;
            q_state <= 1'b0;
            q_valid <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            op      <= op_nxt;
            pref    <= pref_nxt;
            S_n     <= s_n_nxt;
            R_n     <= r_n_nxt;
            busy    <= busy_nxt;
            ack     <= ack_nxt;
            ack_op  <= ack_op_nxt;
            q_state <= q_state_nxt;
            q_valid <= q_valid_nxt;
            err     <= err_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        op_nxt      = op;
        pref_nxt    = pref;
        ack_nxt     = 1'b0;
        ack_op_nxt  = ack_op;
        q_state_nxt = q_state;
        q_valid_nxt = q_valid;
        err_nxt     = err_clr ? 1'b0 : err;

        case (state)
            IDLE: begin
                // pref holds the op opposite to the last one served
                if (set_req || rst_req) begin
                    state_nxt = PULSE;
                    cnt_nxt   = PULSE_LOAD;
                    if (set_req && rst_req) begin
                        op_nxt = pref;
                    end else begin
                        op_nxt = set_req;
                    end
                end
            end
            PULSE: begin
                if (cnt == '0) begin
                    state_nxt = SETTLE;
                    cnt_nxt   = SETTLE_LOAD;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            SETTLE: begin
                if (cnt == '0) begin
                    state_nxt = CHECK;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            CHECK: begin
                state_nxt  = IDLE;
                ack_nxt    = 1'b1;
                ack_op_nxt = op;
                pref_nxt   = ~op;
                // mismatch overrides a coincident err_clr
                if (Q_fb == op) begin
                    q_state_nxt = op;
                    q_valid_nxt = 1'b1;
                end else begin
                    err_nxt     = 1'b1;
                    q_valid_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        s_n_nxt  = !((state_nxt == PULSE) && op_nxt);
        r_n_nxt  = !((state_nxt == PULSE) && !op_nxt);
        busy_nxt = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// Scoreboard bench for sr_latch_ctrl: default instance plus a P=1/S=3 instance,
// each driving a behavioural NAND latch model.
module tb_sr_latch_ctrl;

    typedef struct packed {
        logic op;
        logic q;
        logic v;
        logic e;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic set_a = 1'b0, rreq_a = 1'b0, errclr_a = 1'b0;
    logic s_n_a, r_n_a, busy_a, ack_a, ack_op_a, q_state_a, q_valid_a, err_a;
    logic lat_a, q_fb_a;
    logic force_en = 1'b0;

    logic set_b = 1'b0, rreq_b = 1'b0, errclr_b = 1'b0;
    logic s_n_b, r_n_b, busy_b, ack_b, ack_op_b, q_state_b, q_valid_b, err_b;
    logic lat_b;

    int n_chk = 0;
    int n_fail = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    always #5 clk = ~clk;

    sr_latch_ctrl u_dut_a (
        .clk(clk), .rst_n(rst_n), .set_req(set_a), .rst_req(rreq_a),
        .err_clr(errclr_a), .Q_fb(q_fb_a), .S_n(s_n_a), .R_n(r_n_a),
        .busy(busy_a), .ack(ack_a), .ack_op(ack_op_a), .q_state(q_state_a),
        .q_valid(q_valid_a), .err(err_a)
    );

    sr_latch_ctrl #(.PULSE_CYCLES(1), .SETTLE_CYCLES(3), .CNT_W(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .set_req(set_b), .rst_req(rreq_b),
        .err_clr(errclr_b), .Q_fb(lat_b), .S_n(s_n_b), .R_n(r_n_b),
        .busy(busy_b), .ack(ack_b), .ack_op(ack_op_b), .q_state(q_state_b),
        .q_valid(q_valid_b), .err(err_b)
    );

    // NAND latch models; power-up value unknown
    always @(s_n_a or r_n_a) begin
        if (s_n_a === 1'b0) lat_a = 1'b1;
        else if (r_n_a === 1'b0) lat_a = 1'b0;
    end
    always @(s_n_b or r_n_b) begin
        if (s_n_b === 1'b0) lat_b = 1'b1;
        else if (r_n_b === 1'b0) lat_b = 1'b0;
    end
    assign q_fb_a = force_en ? 1'b0 : lat_a;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // forbidden S=R=0 never driven
    always @(negedge clk) begin
        chk("no_forbidden_a", 8'(s_n_a === 1'b0 && r_n_a === 1'b0), 8'd0);
        chk("no_forbidden_b", 8'(s_n_b === 1'b0 && r_n_b === 1'b0), 8'd0);
    end

    always @(negedge clk) begin
        if (ack_a === 1'b1) begin
            if (qa.size() == 0) begin
                chk("unexpected_ack_a", 8'd1, 8'd0);
            end else begin
                ea = qa.pop_front();
                chk("ack_op_a", 8'(ack_op_a), 8'(ea.op));
                chk("q_state_a", 8'(q_state_a), 8'(ea.q));
                chk("q_valid_a", 8'(q_valid_a), 8'(ea.v));
                chk("err_a", 8'(err_a), 8'(ea.e));
            end
        end
    end

    always @(negedge clk) begin
        if (ack_b === 1'b1) begin
            if (qb.size() == 0) begin
                chk("unexpected_ack_b", 8'd1, 8'd0);
            end else begin
                eb = qb.pop_front();
                chk("ack_op_b", 8'(ack_op_b), 8'(eb.op));
                chk("q_state_b", 8'(q_state_b), 8'(eb.q));
                chk("q_valid_b", 8'(q_valid_b), 8'(eb.v));
                chk("err_b", 8'(err_b), 8'(eb.e));
            end
        end
    end

    task automatic wait_ack_a();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack_a !== 1'b1 && n < 40);
        chk("ack_a_timeout", 8'(ack_a), 8'd1);
    endtask

    // one default-timing op with pulse shape checked edge by edge
    task automatic run_a(input logic op, input exp_t e);
        logic sel, oth;
        @(negedge clk);
        if (op) set_a = 1'b1; else rreq_a = 1'b1;
        qa.push_back(e);
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            sel = op ? s_n_a : r_n_a;
            oth = op ? r_n_a : s_n_a;
            chk("pulse_sel", 8'(sel), (k < 2) ? 8'd0 : 8'd1);
            chk("pulse_other", 8'(oth), 8'd1);
            chk("busy_op", 8'(busy_a), 8'd1);
        end
        @(negedge clk);
        chk("ack_latency", 8'(ack_a), 8'd1);
        set_a  = 1'b0;
        rreq_a = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_S_n", 8'(s_n_a), 8'd1);
        chk("rst_R_n", 8'(r_n_a), 8'd1);
        chk("rst_busy", 8'(busy_a), 8'd0);
        chk("rst_q_valid", 8'(q_valid_a), 8'd0);
        chk("rst_err", 8'(err_a), 8'd0);
        repeat (20) begin
            @(negedge clk);
            chk("idle_quiet", {5'd0, busy_a, s_n_a, r_n_a}, 8'd3);
        end

        // set then reset, single requester
        run_a(1'b1, '{op: 1'b1, q: 1'b1, v: 1'b1, e: 1'b0});
        @(negedge clk);
        chk("no_reaccept", 8'(busy_a), 8'd0);
        run_a(1'b0, '{op: 1'b0, q: 1'b0, v: 1'b1, e: 1'b0});
        repeat (2) @(negedge clk);

        // both requests from fresh reset: reset first, then set
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        set_a = 1'b1;
        rreq_a = 1'b1;
        qa.push_back('{op: 1'b0, q: 1'b0, v: 1'b1, e: 1'b0});
        qa.push_back('{op: 1'b1, q: 1'b1, v: 1'b1, e: 1'b0});
        wait_ack_a();
        wait_ack_a();
        set_a = 1'b0;
        rreq_a = 1'b0;
        repeat (2) @(negedge clk);

        // Q stuck low during set: mismatch, sticky err, then err_clr
        force_en = 1'b1;
        @(negedge clk);
        set_a = 1'b1;
        qa.push_back('{op: 1'b1, q: 1'b1, v: 1'b0, e: 1'b1});
        wait_ack_a();
        set_a = 1'b0;
        force_en = 1'b0;
        repeat (10) @(negedge clk);
        chk("err_sticky", 8'(err_a), 8'd1);
        errclr_a = 1'b1;
        @(negedge clk);
        errclr_a = 1'b0;
        chk("err_cleared", 8'(err_a), 8'd0);

        // reset during PULSE aborts without ack
        @(negedge clk);
        set_a = 1'b1;
        @(negedge clk);
        chk("abort_pulse_low", 8'(s_n_a), 8'd0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_S_n", 8'(s_n_a), 8'd1);
        chk("abort_busy", 8'(busy_a), 8'd0);
        chk("abort_q_valid", 8'(q_valid_a), 8'd0);
        chk("abort_no_ack", 8'(ack_a), 8'd0);
        rst_n = 1'b1;
        set_a = 1'b0;
        @(negedge clk);
        run_a(1'b1, '{op: 1'b1, q: 1'b1, v: 1'b1, e: 1'b0});
        repeat (2) @(negedge clk);

        // short pulse / long settle instance, set_req held through ack
        set_b = 1'b1;
        qb.push_back('{op: 1'b1, q: 1'b1, v: 1'b1, e: 1'b0});
        qb.push_back('{op: 1'b1, q: 1'b1, v: 1'b1, e: 1'b0});
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            chk("b_S_n", 8'(s_n_b), (k == 0 || k == 6) ? 8'd0 : 8'd1);
            chk("b_ack", 8'(ack_b), (k == 5) ? 8'd1 : 8'd0);
            chk("b_busy", 8'(busy_b), (k == 5) ? 8'd0 : 8'd1);
        end
        set_b = 1'b0;
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (ack_b !== 1'b1 && n < 40);
            chk("b_second_ack", 8'(ack_b), 8'd1);
            chk("b_second_latency", 8'(n), 8'd5);
        end
        repeat (3) @(negedge clk);

        chk("a_queue_drained", 8'(qa.size()), 8'd0);
        chk("b_queue_drained", 8'(qb.size()), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
